// File: rtl/scan_chain_driver.sv
// scan_chain_driver: host-side master for a two-phase scan chain.
// Accepts a parallel command, serialises cmd_wdata MSB-first onto scan_in using
// the four-phase bit sequence A (setup) -> P (clkp) -> B (gap) -> N (clkn),
// optionally pulses scan_update, or holds scan_reset for a chain reset.
// Optional feature macro: SCAN_DRIVER_READBACK_EN
//   defined   - scan_out is sampled each bit; rsp_rdata returns prior chain contents
//   undefined - scan_out ignored, zeros shifted into sr, rsp_rdata stays 0
`timescale 1ns/1ps

module scan_chain_driver #(
    parameter int unsigned CHAIN_LEN    = 64,
    parameter int unsigned PHASE_CYCLES = 1,
    parameter int unsigned RST_CYCLES   = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [CHAIN_LEN-1:0] cmd_wdata,
    output logic                 rsp_valid,
    output logic [CHAIN_LEN-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic                 scan_clkp,
    output logic                 scan_clkn,
    output logic                 scan_en,
    output logic                 scan_update,
    output logic                 scan_reset,
    output logic                 scan_in,
    input  logic                 scan_out
);

    localparam int unsigned CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int unsigned PH_MAX = (2 * PHASE_CYCLES > RST_CYCLES) ? 2 * PHASE_CYCLES : RST_CYCLES;
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

    localparam logic [1:0] OP_SHIFT     = 2'b00;
    localparam logic [1:0] OP_SHIFT_UPD = 2'b01;
    localparam logic [1:0] OP_CRST      = 2'b10;
    localparam logic [1:0] OP_RSVD      = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CRST,
        S_SH_A,
        S_SH_P,
        S_SH_B,
        S_SH_N,
        S_UPD,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [PH_W-1:0]      ph_cnt_q, ph_cnt_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [CHAIN_LEN-1:0] sr_q, sr_d;
    logic                 sample_q, sample_d;
    logic [1:0]           op_q, op_d;

    logic                 cmd_ready_q, cmd_ready_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [CHAIN_LEN-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 scan_clkp_q, scan_clkp_d;
    logic                 scan_clkn_q, scan_clkn_d;
    logic                 scan_en_q, scan_en_d;
    logic                 scan_update_q, scan_update_d;
    logic                 scan_reset_q, scan_reset_d;
    logic                 scan_in_q, scan_in_d;

    logic                 ph_last_c;
    logic                 upd_last_c;
    logic                 rst_last_c;
    logic                 bit_last_c;

`ifndef SCAN_DRIVER_READBACK_EN
    // Serial return path is not used when readback is disabled.
    logic                 scan_out_unused;
    assign scan_out_unused = scan_out;
`endif

    // End-of-phase and end-of-chain qualifiers for the current state.
    always_comb begin
        ph_last_c  = (ph_cnt_q == PH_W'(PHASE_CYCLES - 1));
        upd_last_c = (ph_cnt_q == PH_W'(2 * PHASE_CYCLES - 1));
        rst_last_c = (ph_cnt_q == PH_W'(RST_CYCLES - 1));
        bit_last_c = (bit_cnt_q == CNT_W'(CHAIN_LEN - 1));
    end

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d       = state_q;
        ph_cnt_d      = ph_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        sr_d          = sr_q;
        sample_d      = sample_q;
        op_d          = op_q;
        cmd_ready_d   = 1'b0;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = 1'b0;
        scan_clkp_d   = 1'b0;
        scan_clkn_d   = 1'b0;
        scan_en_d     = 1'b0;
        scan_update_d = 1'b0;
        scan_reset_d  = 1'b0;
        scan_in_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    sr_d      = cmd_wdata;
                    bit_cnt_d = '0;
                    ph_cnt_d  = '0;
                    op_d      = cmd_op;
                    case (cmd_op)
                        OP_SHIFT, OP_SHIFT_UPD: state_d = S_SH_A;
                        OP_CRST:                state_d = S_CRST;
                        default:                state_d = S_DONE;
                    endcase
                end
            end
            S_CRST: begin
                if (rst_last_c) begin
                    ph_cnt_d = '0;
                    state_d  = S_DONE;
                end else begin
                    ph_cnt_d = ph_cnt_q + PH_W'(1);
                end
            end
            S_SH_A: begin
                if (ph_last_c) begin
`ifdef SCAN_DRIVER_READBACK_EN
                    sample_d = scan_out;
`else
                    sample_d = 1'b0;
`endif
                    ph_cnt_d = '0;
                    state_d  = S_SH_P;
                end else begin
                    ph_cnt_d = ph_cnt_q + PH_W'(1);
                end
            end
            S_SH_P: begin
                if (ph_last_c) begin
                    ph_cnt_d = '0;
                    state_d  = S_SH_B;
                end else begin
                    ph_cnt_d = ph_cnt_q + PH_W'(1);
                end
            end
            S_SH_B: begin
                if (ph_last_c) begin
                    ph_cnt_d = '0;
                    state_d  = S_SH_N;
                end else begin
                    ph_cnt_d = ph_cnt_q + PH_W'(1);
                end
            end
            S_SH_N: begin
                if (ph_last_c) begin
                    sr_d      = {sr_q[CHAIN_LEN-2:0], sample_q};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    ph_cnt_d  = '0;
                    if (!bit_last_c) begin
                        state_d = S_SH_A;
                    end else if (op_q == OP_SHIFT_UPD) begin
                        state_d = S_UPD;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    ph_cnt_d = ph_cnt_q + PH_W'(1);
                end
            end
            S_UPD: begin
                if (upd_last_c) begin
                    ph_cnt_d = '0;
                    state_d  = S_DONE;
                end else begin
                    ph_cnt_d = ph_cnt_q + PH_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they line up with it.
        cmd_ready_d   = (state_d == S_IDLE);
        scan_en_d     = (state_d == S_SH_A) || (state_d == S_SH_P) ||
                        (state_d == S_SH_B) || (state_d == S_SH_N);
        scan_clkp_d   = (state_d == S_SH_P);
        scan_clkn_d   = (state_d == S_SH_N);
        scan_update_d = (state_d == S_UPD);
        scan_reset_d  = (state_d == S_CRST);
        scan_in_d     = scan_en_d ? sr_d[CHAIN_LEN-1] : 1'b0;
        rsp_valid_d   = (state_d == S_DONE);
        rsp_err_d     = (state_d == S_DONE) && (op_d == OP_RSVD);
        if ((state_d == S_DONE) && (op_d != OP_RSVD)) begin
`ifdef SCAN_DRIVER_READBACK_EN
            rsp_rdata_d = sr_d;
`else
            rsp_rdata_d = '0;
`endif
        end
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            ph_cnt_q      <= '0;
            bit_cnt_q     <= '0;
            sr_q          <= '0;
            sample_q      <= 1'b0;
            op_q          <= OP_SHIFT;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            scan_clkp_q   <= 1'b0;
            scan_clkn_q   <= 1'b0;
            scan_en_q     <= 1'b0;
            scan_update_q <= 1'b0;
            scan_reset_q  <= 1'b0;
            scan_in_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ph_cnt_q      <= ph_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            sr_q          <= sr_d;
            sample_q      <= sample_d;
            op_q          <= op_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            scan_clkp_q   <= scan_clkp_d;
            scan_clkn_q   <= scan_clkn_d;
            scan_en_q     <= scan_en_d;
            scan_update_q <= scan_update_d;
            scan_reset_q  <= scan_reset_d;
            scan_in_q     <= scan_in_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign scan_clkp   = scan_clkp_q;
    assign scan_clkn   = scan_clkn_q;
    assign scan_en     = scan_en_q;
    assign scan_update = scan_update_q;
    assign scan_reset  = scan_reset_q;
    assign scan_in     = scan_in_q;

endmodule
